// File: rtl/register_management_system_pkg.sv
// Shared constants and types for the register management block.
// Field widths, special register addresses and W2 source encodings.
package register_management_system_pkg;

    localparam int DATA_W  = 16;
    localparam int NREGS   = 64;
    localparam int AW      = 6;
    localparam int FC_REGS = 15;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [AW-1:0]     addr_t;

    localparam addr_t CR_ADDR     = 6'd57;
    localparam addr_t IO_IN_ADDR  = 6'd15;
    localparam addr_t IO_OUT_ADDR = 6'd16;

    localparam logic [1:0] SRC_IMM  = 2'd0;
    localparam logic [1:0] SRC_ALU  = 2'd1;
    localparam logic [1:0] SRC_MEM  = 2'd2;
    localparam logic [1:0] SRC_COPY = 2'd3;

endpackage

// File: rtl/register_management_system_regfile.sv
// 64x16 register file: two async read ports, two sync write ports.
// Port 2 is written last so it wins on an address collision.
module rms_regfile
    import register_management_system_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  addr_t                     ra_i,
    input  addr_t                     rb_i,
    output word_t                     ra_o,
    output word_t                     rb_o,
    input  logic                      we1_i,
    input  addr_t                     wa1_i,
    input  word_t                     wd1_i,
    input  logic                      we2_i,
    input  addr_t                     wa2_i,
    input  word_t                     wd2_i,
    output logic [FC_REGS*DATA_W-1:0] fc_o,
    output word_t                     io_o
);

    word_t mem_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (we1_i) mem_q[wa1_i] <= wd1_i;
            if (we2_i) mem_q[wa2_i] <= wd2_i;
        end
    end

    assign ra_o = mem_q[ra_i];
    assign rb_o = mem_q[rb_i];
    assign io_o = mem_q[IO_OUT_ADDR];

    always_comb begin
        fc_o = '0;
        for (int i = 0; i < FC_REGS; i++) begin
            fc_o[i*DATA_W +: DATA_W] = mem_q[i];
        end
    end

endmodule

// File: rtl/register_management_system.sv
// Register management top: decode, read/write muxes, compare, I/O, fcache.
// Define RMS_FWD_EN to forward same-cycle write data onto A/B.
module register_management_system
    import register_management_system_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [15:0]               IR,
    input  logic [DATA_W-1:0]         ImR,
    input  logic [DATA_W-1:0]         w2_1,
    input  logic [DATA_W-1:0]         w2_2,
    input  logic                      AltB,
    input  logic                      writeCR,
    input  logic [1:0]                Regsrc,
    input  logic                      RegR1,
    input  logic                      RegR2,
    input  logic                      RegW1,
    input  logic                      RegW2,
    input  logic                      restore,
    input  logic [FC_REGS*DATA_W-1:0] fcIn,
    input  logic [DATA_W-1:0]         ioIn,
    input  logic                      cmpne,
    input  logic                      cmpeq,
    output logic [DATA_W-1:0]         ioOut,
    output logic [3:0]                op,
    output logic [FC_REGS*DATA_W-1:0] fcOut,
    output logic [DATA_W-1:0]         A,
    output logic [DATA_W-1:0]         B,
    output logic [DATA_W-1:0]         immediate,
    output logic                      cmp_result
);

    addr_t rs, rt, ra;
    word_t ra_data, rb_data;
    word_t rd_a, rd_b, a_base, fc_slice;
    word_t w1_data, w2_data;
    logic  use_fc;

    assign op        = IR[15:12];
    assign rs        = IR[11:6];
    assign rt        = IR[5:0];
    assign immediate = ImR;
    assign ra        = writeCR ? CR_ADDR : rs;

    rms_regfile u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra_i  (ra),
        .rb_i  (rt),
        .ra_o  (ra_data),
        .rb_o  (rb_data),
        .we1_i (RegW1),
        .wa1_i (ra),
        .wd1_i (w1_data),
        .we2_i (RegW2),
        .wa2_i (rt),
        .wd2_i (w2_data),
        .fc_o  (fcOut),
        .io_o  (ioOut)
    );

    // Address 15 is the input port; its stored word is shadowed.
    assign rd_a     = (ra == IO_IN_ADDR) ? ioIn : ra_data;
    assign rd_b     = (rt == IO_IN_ADDR) ? ioIn : rb_data;
    assign a_base   = RegR1 ? rd_a : '0;
    assign use_fc   = restore && (rt < addr_t'(FC_REGS));
    assign fc_slice = fcIn[{rt[3:0], 4'b0000} +: DATA_W];

    always_comb begin
        w2_data = ImR;
        unique case (Regsrc)
            SRC_IMM:  w2_data = ImR;
            SRC_ALU:  w2_data = w2_1;
            SRC_MEM:  w2_data = w2_2;
            SRC_COPY: w2_data = a_base;
        endcase
    end

    assign w1_data = writeCR ? {{(DATA_W-1){1'b0}}, AltB} : w2_1;

`ifdef RMS_FWD_EN
    word_t a_fwd, b_fwd;

    always_comb begin
        a_fwd = rd_a;
        if (ra != IO_IN_ADDR) begin
            if (RegW2 && (rt == ra)) a_fwd = w2_data;
            else if (RegW1)          a_fwd = w1_data;
        end
    end

    always_comb begin
        b_fwd = rd_b;
        if (rt != IO_IN_ADDR) begin
            if (RegW2)                   b_fwd = w2_data;
            else if (RegW1 && ra == rt)  b_fwd = w1_data;
        end
    end

    assign A = RegR1 ? a_fwd : '0;
    assign B = RegR2 ? (use_fc ? fc_slice : b_fwd) : '0;
`else
    assign A = a_base;
    assign B = RegR2 ? (use_fc ? fc_slice : rd_b) : '0;
`endif

    always_comb begin
        cmp_result = 1'b0;
        if (cmpeq)      cmp_result = (A == B);
        else if (cmpne) cmp_result = (A != B);
    end

endmodule

// File: tb/tb_register_management_system.sv
// Directed self-checking bench for register_management_system.
module tb_register_management_system;

    logic         clk;
    logic         rst_n;
    logic [15:0]  IR, ImR, w2_1, w2_2, ioIn;
    logic         AltB, writeCR, RegR1, RegR2, RegW1, RegW2;
    logic         restore, cmpne, cmpeq;
    logic [1:0]   Regsrc;
    logic [239:0] fcIn;
    logic [15:0]  ioOut, A, B, immediate;
    logic [3:0]   op;
    logic [239:0] fcOut;
    logic         cmp_result;

    int errors = 0;
    int checks = 0;

    register_management_system dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .IR         (IR),
        .ImR        (ImR),
        .w2_1       (w2_1),
        .w2_2       (w2_2),
        .AltB       (AltB),
        .writeCR    (writeCR),
        .Regsrc     (Regsrc),
        .RegR1      (RegR1),
        .RegR2      (RegR2),
        .RegW1      (RegW1),
        .RegW2      (RegW2),
        .restore    (restore),
        .fcIn       (fcIn),
        .ioIn       (ioIn),
        .cmpne      (cmpne),
        .cmpeq      (cmpeq),
        .ioOut      (ioOut),
        .op         (op),
        .fcOut      (fcOut),
        .A          (A),
        .B          (B),
        .immediate  (immediate),
        .cmp_result (cmp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mk_ir(input int o, input int s, input int t);
        logic [3:0] o4;
        logic [5:0] s6, t6;
        o4 = o[3:0];
        s6 = s[5:0];
        t6 = t[5:0];
        return {o4, s6, t6};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; IR = 16'h0; ImR = 16'h0; w2_1 = 16'h0; w2_2 = 16'h0;
        ioIn = 16'h0; AltB = 1'b0; writeCR = 1'b0; Regsrc = 2'd0;
        RegR1 = 1'b0; RegR2 = 1'b0; RegW1 = 1'b0; RegW2 = 1'b0;
        restore = 1'b0; cmpne = 1'b0; cmpeq = 1'b0; fcIn = '0;
        #12;
        RegR1 = 1'b1; RegR2 = 1'b1; IR = mk_ir(0, 3, 20);
        #1;
        checks++;
        if (fcOut !== 240'h0) begin
            errors++; $display("FAIL reset_fcOut got=%h exp=0", fcOut);
        end
        checks++;
        if (ioOut !== 16'h0) begin
            errors++; $display("FAIL reset_ioOut got=%h exp=0", ioOut);
        end
        checks++;
        if (A !== 16'h0 || B !== 16'h0) begin
            errors++; $display("FAIL reset_AB got=%h/%h exp=0/0", A, B);
        end
        RegR1 = 1'b0; RegR2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill_sweep;
        RegW2 = 1'b1; Regsrc = 2'd0; writeCR = 1'b0;
        for (int n = 1; n < 64; n++) begin
            IR = mk_ir(0, 0, n);
            ImR = 16'(n);
            tick();
        end
        RegW2 = 1'b0; RegR1 = 1'b1; RegR2 = 1'b1;
        for (int s = 0; s < 30; s++) begin
            for (int t = 0; t < 30; t++) begin
                IR = mk_ir(s, s, t);
                ioIn = 16'hF00D;
                #1;
                if (s != 15) begin
                    checks++;
                    if (A !== 16'(s)) begin
                        errors++; $display("FAIL sweep_A rs=%0d got=%0d exp=%0d", s, A, s);
                    end
                end
                if (t != 15) begin
                    checks++;
                    if (B !== 16'(t)) begin
                        errors++; $display("FAIL sweep_B rt=%0d got=%0d exp=%0d", t, B, t);
                    end
                end
            end
            checks++;
            if (op !== 4'(s)) begin
                errors++; $display("FAIL sweep_op got=%0d exp=%0d", op, s % 16);
            end
        end
        writeCR = 1'b1;
        for (int s = 0; s < 30; s++) begin
            IR = mk_ir(0, s, 1);
            #1;
            checks++;
            if (A !== 16'd57) begin
                errors++; $display("FAIL sweep_cr rs=%0d got=%0d exp=57", s, A);
            end
        end
        writeCR = 1'b0; ioIn = 16'h0;
    endtask

    task automatic test_regsrc;
        logic [15:0] exp_b;
        writeCR = 1'b1; IR = 16'h0; RegW2 = 1'b1; RegR1 = 1'b1; RegR2 = 1'b1;
        ImR = 16'd5; w2_1 = 16'd10; w2_2 = 16'd15;
        for (int s = 0; s < 4; s++) begin
            Regsrc = 2'(s);
            case (s)
                0: exp_b = 16'd5;
                1: exp_b = 16'd10;
                2: exp_b = 16'd15;
                default: exp_b = 16'd57;
            endcase
            tick();
            checks++;
            if (B !== exp_b) begin
                errors++; $display("FAIL regsrc_B sel=%0d got=%0d exp=%0d", s, B, exp_b);
            end
            checks++;
            if (A !== 16'd57) begin
                errors++; $display("FAIL regsrc_A sel=%0d got=%0d exp=57", s, A);
            end
        end
        checks++;
        if (immediate !== 16'd5) begin
            errors++; $display("FAIL immediate got=%0d exp=5", immediate);
        end
        RegW2 = 1'b0; writeCR = 1'b0; Regsrc = 2'd0;
    endtask

    task automatic test_fcache;
        logic [239:0] exp_fc;
        RegW2 = 1'b1; Regsrc = 2'd0; IR = 16'h0; ImR = 16'h0;
        tick();
        RegW2 = 1'b0;
        exp_fc = '0;
        for (int i = 0; i < 15; i++) exp_fc[i*16 +: 16] = 16'(i);
        checks++;
        if (fcOut !== exp_fc) begin
            errors++; $display("FAIL fcOut got=%h exp=%h", fcOut, exp_fc);
        end
    endtask

    task automatic test_restore;
        for (int i = 0; i < 15; i++) fcIn[i*16 +: 16] = 16'(14 - i);
        restore = 1'b1; RegR2 = 1'b1;
        for (int i = 0; i < 15; i++) begin
            IR = mk_ir(0, 0, i);
            #1;
            checks++;
            if (B !== 16'(14 - i)) begin
                errors++; $display("FAIL restore_B rt=%0d got=%0d exp=%0d", i, B, 14 - i);
            end
        end
        IR = mk_ir(0, 0, 16);
        #1;
        checks++;
        if (B !== 16'd16) begin
            errors++; $display("FAIL restore_hi got=%0d exp=16", B);
        end
        restore = 1'b0;
    endtask

    task automatic test_compare;
        writeCR = 1'b1; IR = 16'h0; RegW2 = 1'b1; Regsrc = 2'd0;
        RegR1 = 1'b1; RegR2 = 1'b1;
        for (int m = 0; m < 2; m++) begin
            cmpeq = (m == 0); cmpne = (m == 1);
            for (int v = 40; v < 60; v++) begin
                ImR = 16'(v);
                tick();
                checks++;
                if (cmp_result !== ((v == 57) ^ (m == 1))) begin
                    errors++;
                    $display("FAIL cmp mode=%0d v=%0d got=%b exp=%b",
                             m, v, cmp_result, (v == 57) ^ (m == 1));
                end
            end
        end
        cmpeq = 1'b1; cmpne = 1'b1;
        #1;
        checks++;
        if (cmp_result !== 1'b0) begin
            errors++; $display("FAIL cmp_both got=%b exp=0", cmp_result);
        end
        cmpeq = 1'b0; cmpne = 1'b0;
        #1;
        checks++;
        if (cmp_result !== 1'b0) begin
            errors++; $display("FAIL cmp_none got=%b exp=0", cmp_result);
        end
        RegW2 = 1'b0; writeCR = 1'b0;
    endtask

    task automatic test_io;
        IR = mk_ir(0, 15, 16); Regsrc = 2'd2; RegW2 = 1'b1;
        RegR1 = 1'b1; RegR2 = 1'b1;
        for (int k = 0; k < 15; k++) begin
            ioIn = 16'(k + 100); w2_2 = 16'(k);
            #1;
            checks++;
            if (A !== 16'(k + 100)) begin
                errors++; $display("FAIL io_A got=%0d exp=%0d", A, k + 100);
            end
            tick();
            checks++;
            if (ioOut !== 16'(k) || B !== 16'(k)) begin
                errors++; $display("FAIL io_out got=%0d/%0d exp=%0d", ioOut, B, k);
            end
        end
        RegW2 = 1'b0; Regsrc = 2'd0;
    endtask

    task automatic test_conflict;
        IR = mk_ir(0, 20, 20); RegW1 = 1'b1; RegW2 = 1'b1;
        w2_1 = 16'h1111; ImR = 16'h2222; Regsrc = 2'd0;
        tick();
        RegW1 = 1'b0; RegW2 = 1'b0;
        #1;
        checks++;
        if (B !== 16'h2222) begin
            errors++; $display("FAIL conflict got=%h exp=2222", B);
        end
        IR = mk_ir(0, 21, 0); RegW1 = 1'b1; w2_1 = 16'hBEEF;
        tick();
        RegW1 = 1'b0;
        #1;
        checks++;
        if (A !== 16'hBEEF) begin
            errors++; $display("FAIL w1_write got=%h exp=beef", A);
        end
        writeCR = 1'b1; RegW1 = 1'b1; AltB = 1'b1;
        tick();
        RegW1 = 1'b0; AltB = 1'b0;
        #1;
        checks++;
        if (A !== 16'h0001) begin
            errors++; $display("FAIL cr_write got=%h exp=0001", A);
        end
        writeCR = 1'b0;
    endtask

    task automatic test_reset_mid;
        IR = mk_ir(0, 16, 3); RegR1 = 1'b1; RegR2 = 1'b1;
        #1;
        checks++;
        if (A !== 16'd14 || B !== 16'd3) begin
            errors++; $display("FAIL pre_reset got=%0d/%0d exp=14/3", A, B);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (A !== 16'h0 || B !== 16'h0) begin
            errors++; $display("FAIL mid_reset_AB got=%h/%h exp=0/0", A, B);
        end
        checks++;
        if (ioOut !== 16'h0 || fcOut !== 240'h0) begin
            errors++; $display("FAIL mid_reset_io got=%h fc=%h exp=0", ioOut, fcOut);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill_sweep();
        test_regsrc();
        test_fcache();
        test_restore();
        test_compare();
        test_io();
        test_conflict();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
